// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexes NSRC byte sources onto one LED bus with a one-hot group select.
// Define LED_SCAN_BLANK_EN to insert BLANK dark cycles between slots.
module led_scan_ctrl #(
  parameter int NSRC   = 4,
  parameter int SLOT_W = 2,
  parameter int DWELL  = 16,
  parameter int BLANK  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8*NSRC-1:0]   src_bus,
  input  logic [NSRC-1:0]     en_mask,
  input  logic                freeze,
  output logic [7:0]          out,
  output logic [NSRC-1:0]     sel_out,
  output logic [SLOT_W-1:0]   slot,
  output logic                frame_done
);
  localparam int CMAX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
`ifdef LED_SCAN_BLANK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_BLANK} state_t;
`else
  typedef enum logic {ST_IDLE, ST_SHOW} state_t;
`endif
  state_t              r_state;
  logic [7:0]          r_out;
  logic [NSRC-1:0]     r_sel;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_frame;
  logic [CW-1:0]       r_cnt;
  logic [SLOT_W-1:0]   w_first, w_above, w_nxt;
  logic                w_hit, w_dwell_end;
  logic [7:0]          w_src_first;
  assign out        = r_out;
  assign sel_out    = r_sel;
  assign slot       = r_slot;
  assign frame_done = r_frame;
  // Descending scan so the lowest qualifying bit is the one left standing.
  always_comb begin
    w_first = '0;
    w_above = '0;
    w_hit   = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (en_mask[k]) w_first = SLOT_W'(k);
      if (en_mask[k] && k > int'(r_slot)) begin
        w_above = SLOT_W'(k);
        w_hit   = 1'b1;
      end
    end
    w_nxt = w_hit ? w_above : w_first;
  end
  assign w_src_first = src_bus[{w_first, 3'b000} +: 8];
  assign w_dwell_end = r_cnt == CW'(DWELL - 1);
`ifdef LED_SCAN_BLANK_EN
  logic [7:0] w_src_slot;
  assign w_src_slot = src_bus[{r_slot, 3'b000} +: 8];
`else
  logic [7:0] w_src_nxt;
  assign w_src_nxt = src_bus[{w_nxt, 3'b000} +: 8];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_sel   <= '0;
      r_slot  <= '0;
      r_frame <= 1'b0;
      r_cnt   <= '0;
    end else if (en_mask == '0) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_sel   <= '0;
      r_frame <= 1'b0;
      r_cnt   <= '0;
    end else if (freeze) begin
      r_frame <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_state <= ST_SHOW;
        r_slot  <= w_first;
        r_out   <= w_src_first;
        r_sel   <= NSRC'(1) << w_first;
        r_cnt   <= '0;
      end else if (r_state == ST_SHOW) begin
        if (w_dwell_end) begin
          r_slot  <= w_nxt;
          r_frame <= (w_nxt <= r_slot);
          r_cnt   <= '0;
`ifdef LED_SCAN_BLANK_EN
          r_state <= ST_BLANK;
          r_out   <= '0;
          r_sel   <= '0;
`else
          r_out   <= w_src_nxt;
          r_sel   <= NSRC'(1) << w_nxt;
`endif
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
`ifdef LED_SCAN_BLANK_EN
      else if (r_cnt == CW'(BLANK - 1)) begin
        r_state <= ST_SHOW;
        r_out   <= w_src_slot;
        r_sel   <= NSRC'(1) << r_slot;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
`endif
    end
  end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: table-driven scan sequences with a scoreboard, plus async reset and DWELL=1 corners.
module tb_led_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src_bus;
  logic [3:0]  en_mask = '0;
  logic        freeze = 1'b0;
  logic [7:0]  out;
  logic [3:0]  sel_out;
  logic [1:0]  slot;
  logic        frame_done;
  logic [15:0] src1 = 16'hBBAA;
  logic [7:0]  o1;
  logic [1:0]  sel1;
  logic        slot1, fd1;

  always #5 clk = ~clk;

  led_scan_ctrl #(.NSRC(4), .SLOT_W(2), .DWELL(4), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .src_bus(src_bus), .en_mask(en_mask), .freeze(freeze),
    .out(out), .sel_out(sel_out), .slot(slot), .frame_done(frame_done));

  led_scan_ctrl #(.NSRC(2), .SLOT_W(1), .DWELL(1), .BLANK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .src_bus(src1), .en_mask(2'b11), .freeze(1'b0),
    .out(o1), .sel_out(sel1), .slot(slot1), .frame_done(fd1));

  typedef struct {
    logic [3:0] mask;
    logic       frz;
    int         n;
    logic [7:0] out;
    logic [3:0] sel;
    logic [1:0] slot;
    logic       fd;
    logic       xs;
  } row_t;
  typedef struct {
    logic [7:0] out;
    logic [3:0] sel;
    logic [1:0] slot;
    logic       fd;
    logic       xs;
    int         id;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];
  int   passed = 0, total = 0;

  task automatic add(input logic [3:0] m, input logic f, input int n, input logic [7:0] o,
                     input logic [3:0] s, input logic [1:0] sl, input logic fd, input logic xs = 1'b0);
    row_t r;
    r = '{m, f, n, o, s, sl, fd, xs};
    rows.push_back(r);
  endtask

  task automatic check(input exp_t e);
    total++;
    if (out === e.out && sel_out === e.sel && frame_done === e.fd && (e.xs || slot === e.slot))
      passed++;
    else
      $display("FAIL scan row %0d @%0t: got out=%h sel=%b slot=%0d fd=%b, want out=%h sel=%b slot=%0d fd=%b",
               e.id, $time, out, sel_out, slot, frame_done, e.out, e.sel, e.slot, e.fd);
  endtask

  task automatic step(input row_t r, input int id);
    exp_t e;
    en_mask = r.mask;
    freeze  = r.frz;
    e = '{r.out, r.sel, r.slot, r.fd, r.xs, id};
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(sb.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int a, input int b);
    for (int i = a; i < b; i++)
      for (int c = 0; c < rows[i].n; c++) step(rows[i], i);
  endtask

  initial begin
    int   split;
    row_t r;
    exp_t e;
    src_bus = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef LED_SCAN_BLANK_EN
    add(4'b0011, 0, 4, 8'h11, 4'b0001, 0, 0);
    add(4'b0011, 0, 2, 8'h00, 4'b0000, 1, 0);
    add(4'b0011, 0, 4, 8'h22, 4'b0010, 1, 0);
    add(4'b0011, 0, 1, 8'h00, 4'b0000, 0, 1);
    add(4'b0011, 0, 1, 8'h00, 4'b0000, 0, 0);
    add(4'b0011, 0, 4, 8'h11, 4'b0001, 0, 0);
    add(4'b0011, 0, 1, 8'h00, 4'b0000, 1, 0);
    add(4'b0011, 1, 3, 8'h00, 4'b0000, 1, 0);
    add(4'b0011, 0, 1, 8'h00, 4'b0000, 1, 0);
    add(4'b0011, 0, 4, 8'h22, 4'b0010, 1, 0);
    add(4'b0011, 0, 1, 8'h00, 4'b0000, 0, 1);
    add(4'b0000, 0, 2, 8'h00, 4'b0000, 0, 0, 1);
    add(4'b0011, 0, 4, 8'h11, 4'b0001, 0, 0);
    add(4'b0100, 0, 2, 8'h00, 4'b0000, 2, 0);
    add(4'b0100, 0, 1, 8'h33, 4'b0100, 2, 0);
    split = rows.size();
    add(4'b0011, 0, 4, 8'h11, 4'b0001, 0, 0);
    add(4'b0011, 0, 2, 8'h00, 4'b0000, 1, 0);
    add(4'b0011, 0, 4, 8'h22, 4'b0010, 1, 0);
    add(4'b0011, 0, 1, 8'h00, 4'b0000, 0, 1);
`else
    add(4'b1111, 0, 4, 8'h11, 4'b0001, 0, 0);
    add(4'b1111, 0, 4, 8'h22, 4'b0010, 1, 0);
    add(4'b1111, 0, 4, 8'h33, 4'b0100, 2, 0);
    add(4'b1111, 0, 4, 8'h44, 4'b1000, 3, 0);
    add(4'b1111, 0, 1, 8'h11, 4'b0001, 0, 1);
    add(4'b1111, 0, 3, 8'h11, 4'b0001, 0, 0);
    add(4'b1111, 0, 4, 8'h22, 4'b0010, 1, 0);
    add(4'b1111, 0, 4, 8'h33, 4'b0100, 2, 0);
    add(4'b1111, 0, 4, 8'h44, 4'b1000, 3, 0);
    add(4'b1010, 0, 1, 8'h22, 4'b0010, 1, 1);
    add(4'b1010, 0, 3, 8'h22, 4'b0010, 1, 0);
    add(4'b1010, 0, 4, 8'h44, 4'b1000, 3, 0);
    add(4'b1010, 0, 1, 8'h22, 4'b0010, 1, 1);
    add(4'b1010, 0, 3, 8'h22, 4'b0010, 1, 0);
    add(4'b1010, 0, 4, 8'h44, 4'b1000, 3, 0);
    add(4'b1111, 0, 1, 8'h11, 4'b0001, 0, 1);
    add(4'b1111, 0, 3, 8'h11, 4'b0001, 0, 0);
    add(4'b1111, 0, 4, 8'h22, 4'b0010, 1, 0);
    add(4'b1111, 0, 2, 8'h33, 4'b0100, 2, 0);
    add(4'b1111, 1, 5, 8'h33, 4'b0100, 2, 0);
    add(4'b1111, 0, 2, 8'h33, 4'b0100, 2, 0);
    add(4'b1111, 0, 4, 8'h44, 4'b1000, 3, 0);
    add(4'b1111, 0, 1, 8'h11, 4'b0001, 0, 1);
    add(4'b1111, 0, 3, 8'h11, 4'b0001, 0, 0);
    add(4'b1111, 0, 2, 8'h22, 4'b0010, 1, 0);
    add(4'b0000, 0, 2, 8'h00, 4'b0000, 0, 0, 1);
    add(4'b0100, 1, 2, 8'h00, 4'b0000, 0, 0, 1);
    add(4'b0100, 0, 1, 8'h33, 4'b0100, 2, 0);
    add(4'b0100, 0, 3, 8'h33, 4'b0100, 2, 0);
    add(4'b0100, 0, 1, 8'h33, 4'b0100, 2, 1);
    add(4'b0100, 1, 3, 8'h33, 4'b0100, 2, 0);
    add(4'b0000, 1, 1, 8'h00, 4'b0000, 0, 0, 1);
    add(4'b0100, 0, 1, 8'h33, 4'b0100, 2, 0);
    split = rows.size();
    add(4'b1010, 0, 4, 8'h22, 4'b0010, 1, 0);
    add(4'b1010, 0, 4, 8'h44, 4'b1000, 3, 0);
    add(4'b1010, 0, 1, 8'h22, 4'b0010, 1, 1);
`endif
    @(posedge clk);
    #1;
    e = '{8'h00, 4'b0000, 2'd0, 1'b0, 1'b0, -1};
    sb.push_back(e);
    check(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    run(0, split);
    src_bus[23:16] = 8'h99;
    r = '{4'b0100, 1'b0, 1, 8'h33, 4'b0100, 2'd2, 1'b0, 1'b0};
    step(r, -2);
    src_bus[23:16] = 8'h33;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    e = '{8'h00, 4'b0000, 2'd0, 1'b0, 1'b0, -3};
    sb.push_back(e);
    check(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    run(split, rows.size());
`ifndef LED_SCAN_BLANK_EN
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (o1 === ((c % 2) ? 8'hBB : 8'hAA) && sel1 === ((c % 2) ? 2'b10 : 2'b01) &&
          slot1 === 1'(c % 2) && fd1 === (c > 0 && c % 2 == 0))
        passed++;
      else
        $display("FAIL dwell1 cycle %0d: got out=%h sel=%b slot=%0d fd=%b", c, o1, sel1, slot1, fd1);
    end
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Time-multiplexes up to NSRC 8-bit display sources (acc, addr, pc, ir, ...) onto the single shared 8-bit LED bus.
- Drives a one-hot group select alongside the bus.
- Each enabled source gets a fixed dwell window; disabled sources are skipped.
- A freeze input holds the current display, and a pulse marks each completed scan frame. It replaces fixed two-phase toggling as the scheduler of the LED pin-out.

Parameters:
- NSRC, 4, number of sources; 2..8.
- SLOT_W, 2, slot index width; must satisfy 2**SLOT_W >= NSRC.
- DWELL, 16, cycles each slot is shown; >= 1.
- BLANK, 2, blanking cycles between slots; >= 1; used only with LED_SCAN_BLANK_EN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_bus  in  8*NSRC  source k occupies bits [8k+7:8k].
- en_mask  in  NSRC  bit k=1 includes source k in the scan.
- freeze  in  1  1 = hold the current slot and outputs.
- out  out  8  LED data bus, registered.
- sel_out  out  NSRC  one-hot select for the slot shown; all-zero when idle or blanking.
- slot  out  SLOT_W  index of the slot currently selected.
- frame_done  out  1  one-cycle pulse at scan wrap.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, sel_out=0, slot=0, frame_done=0, dwell counter=0. Outputs clear immediately, independent of clk.
- States: IDLE, SHOW, BLANK (BLANK exists only with the macro).
- IDLE:
  - out=0, sel_out=0.
  - When en_mask!=0 and freeze=0, the next edge enters SHOW with slot = lowest set bit of en_mask.
- SHOW entry (same edge):
  - out <= src_bus[8*slot+:8], captured once per slot and stable for the whole dwell. Source changes mid-dwell are not shown until the next visit.
  - sel_out <= 1<<slot; counter <= 0.
- SHOW dwell:
  - Counter increments each edge while freeze=0.
  - At counter==DWELL-1 with freeze=0, compute nxt = next set bit of en_mask strictly above slot, wrapping to the lowest set bit. Sample en_mask at this edge.
  - Without the macro: enter SHOW of nxt on the same edge, so there is no gap. A visible slot lasts exactly DWELL cycles.
- frame_done: 1 for exactly one cycle, on the edge that moves to nxt, when nxt <= slot (wrap). A single enabled source therefore pulses every DWELL cycles.
- en_mask mid-dwell:
  - Changes are ignored until the slot boundary, except en_mask==0.
  - en_mask==0 forces IDLE on the next edge with out=0 and sel_out=0, regardless of freeze. No frame_done is issued.
- freeze=1:
  - Counter and state stall; out, sel_out and slot hold.
  - Release resumes from the held count; the slot is not restarted.
  - In IDLE, freeze blocks leaving IDLE.
- A boundary coinciding with freeze=1 is not taken until freeze falls.
- DWELL=1 with NSRC=2 and en_mask=2'b11 alternates slots every cycle.

Optional Feature:
- Macro: LED_SCAN_BLANK_EN.
- Defined: on a dwell end, enter BLANK for exactly BLANK cycles.
  - out=0 and sel_out=0 during BLANK; slot already shows nxt; frame_done pulses on entry to BLANK.
  - The edge after the last blank cycle enters SHOW of nxt, capturing the source then.
  - freeze stalls the blank counter; en_mask==0 during BLANK goes to IDLE.
- Undefined: no BLANK state or counter is synthesized; transitions are back-to-back as above.

Test Plan:
1. Reset then en_mask=4'b1111, DWELL=4, src0..3=8'h11,22,33,44 -> out shows 11,22,33,44 for 4 cycles each; sel_out walks 0001,0010,0100,1000; frame_done pulses once at the 44->11 edge; repeats every 16 cycles.
2. en_mask=4'b1010 -> only slots 1 and 3 are shown (22, 44); slots 0 and 2 never assert sel_out; frame_done every 8 cycles.
3. freeze=1 for 5 cycles at dwell count 2 of slot 2 -> out=33 and sel_out=0100 for 2+5+2 cycles in total, then slot 3.
4. en_mask driven to 0 mid-slot 1 -> next edge out=0, sel_out=0, IDLE; mask restored to 4'b0100 -> SHOW slot 2 the next edge.
5. rst_n pulsed low mid-dwell, asynchronous to clk -> out=0, sel_out=0, slot=0 without waiting for a clock edge; scan restarts at the lowest enabled slot.
6. LED_SCAN_BLANK_EN defined, BLANK=2, DWELL=4, mask=4'b0011 -> pattern 11×4, 00×2 with sel_out=0, 22×4, 00×2; frame_done on entry to the blank that precedes slot 0.
